ew_threat_fsm: RTL and testbench
================================

EW_THREAT_FSM -- requirements
Module: ew_threat_fsm

Interface
REQ-001 Parameters SHALL be:
- FSM_BITS, default 3, state encoding width.
- ENT_TIMEOUT, default 32, maximum cycles spent in JAMMED or SPOOF_DETECTED waiting for ent_valid.
- CM_TIMEOUT, default 64, maximum cycles spent in COUNTER_MEASURE waiting for cm_ack.
- REC_CYCLES, default 16, number of cycles spent in RECOVERY.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- jam_det  in  1  jamming detected.
- spoof_det  in  1  spoofing detected.
- ent_valid  in  1  entropy result strobe.
- ent_high  in  1  entropy verdict; qualified by ent_valid.
- cm_ack  in  1  countermeasure complete.
- fsm_state  out  FSM_BITS  current state register.
- ent_req  out  1  entropy analysis request.
- cm_req  out  1  countermeasure request.
- cm_timeout_err  out  1  sticky CM timeout flag.
- threat_cnt  out  8  saturating threat-entry count.

Function
REQ-003 State encoding SHALL be IDLE=0, MONITOR=1, JAMMED=2, SPOOF_DETECTED=3, ENTROPY_ANALYZED=4, COUNTER_MEASURE=5, RECOVERY=6; fsm_state SHALL never hold 7.
REQ-004 fsm_state SHALL be driven directly from the state register (Moore); all transitions SHALL take effect on the clock edge after the causing inputs are sampled.
REQ-005 IDLE SHALL go to MONITOR on the next cycle, unconditionally.
REQ-006 MONITOR: jam_det=1 SHALL go to JAMMED; else spoof_det=1 SHALL go to SPOOF_DETECTED; else MONITOR SHALL hold. When both are asserted, JAMMED wins.
REQ-007 JAMMED and SPOOF_DETECTED: ent_req=1. ent_valid=1 SHALL go to ENTROPY_ANALYZED and latch ent_high into an internal verdict flag.
REQ-008 In JAMMED or SPOOF_DETECTED, if ENT_TIMEOUT cycles elapse after entry without ent_valid, the state SHALL go to COUNTER_MEASURE (fail-safe). If ent_valid and the timeout occur in the same cycle, ent_valid wins.
REQ-009 JAMMED SHALL never transition directly to RECOVERY, MONITOR or IDLE.
REQ-010 ENTROPY_ANALYZED SHALL last exactly one cycle: verdict=1 goes to COUNTER_MEASURE; verdict=0 goes to MONITOR.
REQ-011 COUNTER_MEASURE: cm_req=1. cm_ack=1 SHALL go to RECOVERY.
REQ-012 In COUNTER_MEASURE, after CM_TIMEOUT cycles without cm_ack, the state SHALL go to RECOVERY and cm_timeout_err SHALL be set. If ack and timeout occur in the same cycle, ack wins and no error is set.
REQ-013 RECOVERY SHALL last exactly REC_CYCLES cycles, then go to MONITOR; jam_det and spoof_det SHALL be ignored during RECOVERY.
REQ-014 cm_ack outside COUNTER_MEASURE and ent_valid outside JAMMED/SPOOF_DETECTED SHALL be ignored.
REQ-015 threat_cnt SHALL increment by 1 on each entry into JAMMED or SPOOF_DETECTED and saturate at 255.
REQ-016 cm_timeout_err SHALL stay set until rst.

Reset
REQ-017 While rst=1: fsm_state=IDLE, ent_req=0, cm_req=0, cm_timeout_err=0, threat_cnt=0, verdict flag=0, timer=0.
REQ-018 Reset asserted in any state, including mid-handshake, SHALL take effect at the next edge and abandon any pending request.

Configuration
REQ-019 Macro EW_THREAT_CNT_EN defined: threat_cnt counter is implemented per REQ-015.
REQ-020 Macro EW_THREAT_CNT_EN undefined: threat_cnt is tied to 0 and no counter register exists; all other behaviour is unchanged.

Structure
REQ-021 Package ew_pkg SHALL hold the fsm_state_t enum (REQ-003 encoding) and the default timeout/dwell constants; the block SHALL import it.
REQ-022 The block SHALL contain one sub-module, ew_dwell_timer: a loadable down-counter with load, value and expired signals, reloaded on each state entry and shared by the ENT_TIMEOUT, CM_TIMEOUT and REC_CYCLES uses.

Verification
REQ-023 Release rst -> cycle 1 IDLE, cycle 2 MONITOR, threat_cnt=0.
REQ-024 MONITOR with jam_det=spoof_det=1 -> JAMMED, threat_cnt=1; ent_valid=1, ent_high=1 on cycle 3 -> ENTROPY_ANALYZED, then COUNTER_MEASURE; cm_ack on cycle 5 -> RECOVERY for 16 cycles -> MONITOR.
REQ-025 SPOOF_DETECTED with no ent_valid for 32 cycles -> COUNTER_MEASURE; the bench checks JAMMED is never followed by RECOVERY across 10k random cycles.
REQ-026 COUNTER_MEASURE without cm_ack for 64 cycles -> RECOVERY, cm_timeout_err=1 persisting; ack on exactly cycle 64 -> RECOVERY, cm_timeout_err=0.
REQ-027 Run 300 threat entries -> threat_cnt=255 (macro defined) or 0 (macro undefined).
REQ-028 Assert rst while in COUNTER_MEASURE with cm_req=1 -> next edge IDLE, cm_req=0, all outputs at reset values.

Source files
------------

// File: rtl/ew_pkg.sv
// +--------------------------------------------------------------------------+
// | ew_pkg : shared state encoding and default dwell/timeout constants.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ew_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_MONITOR       = 3'd1,
    ST_JAMMED        = 3'd2,
    ST_SPOOF         = 3'd3,
    ST_ENT_ANALYZED  = 3'd4,
    ST_COUNTER_MEAS  = 3'd5,
    ST_RECOVERY      = 3'd6
  } fsm_state_t;

  localparam int c_ent_timeout = 32;
  localparam int c_cm_timeout  = 64;
  localparam int c_rec_cycles  = 16;

  function automatic logic is_threat(input fsm_state_t s);
    return (s == ST_JAMMED) || (s == ST_SPOOF);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ew_threat_fsm_dwell_timer.sv
// +--------------------------------------------------------------------------+
// | ew_dwell_timer : loadable down-counter, expired when the count is zero.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ew_dwell_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_value,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value   = r_value;
  assign o_expired = (r_value == '0);

endmodule

`default_nettype wire

// File: rtl/ew_threat_fsm.sv
// +--------------------------------------------------------------------------+
// | ew_threat_fsm : EW threat response controller (Moore FSM).               |
// | Optional threat entry counter enabled by macro EW_THREAT_CNT_EN.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ew_threat_fsm
  import ew_pkg::*;
#(
  parameter int FSM_BITS    = 3,
  parameter int ENT_TIMEOUT = c_ent_timeout,
  parameter int CM_TIMEOUT  = c_cm_timeout,
  parameter int REC_CYCLES  = c_rec_cycles
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jam_det,
  input  logic                spoof_det,
  input  logic                ent_valid,
  input  logic                ent_high,
  input  logic                cm_ack,
  output logic [FSM_BITS-1:0] fsm_state,
  output logic                ent_req,
  output logic                cm_req,
  output logic                cm_timeout_err,
  output logic [7:0]          threat_cnt
);

  localparam int c_tmr_max = max3(ENT_TIMEOUT, CM_TIMEOUT, REC_CYCLES);
  localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

  // Timer holds N-1 on the first cycle of a state, so it expires on cycle N.
  localparam logic [c_tmr_w-1:0] c_ent_load = c_tmr_w'(ENT_TIMEOUT - 1);
  localparam logic [c_tmr_w-1:0] c_cm_load  = c_tmr_w'(CM_TIMEOUT - 1);
  localparam logic [c_tmr_w-1:0] c_rec_load = c_tmr_w'(REC_CYCLES - 1);

  fsm_state_t           r_state;
  fsm_state_t           w_next;
  logic                 r_verdict;
  logic                 r_cm_err;
  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_tmr_load_val;
  logic [c_tmr_w-1:0]   w_tmr_value;
  logic                 w_tmr_expired;
  logic                 w_unused_tmr;

  ew_dwell_timer #(
    .WIDTH (c_tmr_w)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_value    (w_tmr_value),
    .o_expired  (w_tmr_expired)
  );

  assign w_unused_tmr = ^w_tmr_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (jam_det) begin
          w_next = ST_JAMMED;
        end else if (spoof_det) begin
          w_next = ST_SPOOF;
        end
      end
      ST_JAMMED, ST_SPOOF: begin
        // A verdict arriving on the final allowed cycle beats the fail-safe.
        if (ent_valid) begin
          w_next = ST_ENT_ANALYZED;
        end else if (w_tmr_expired) begin
          w_next = ST_COUNTER_MEAS;
        end
      end
      ST_ENT_ANALYZED: begin
        w_next = r_verdict ? ST_COUNTER_MEAS : ST_MONITOR;
      end
      ST_COUNTER_MEAS: begin
        if (cm_ack || w_tmr_expired) begin
          w_next = ST_RECOVERY;
        end
      end
      ST_RECOVERY: begin
        if (w_tmr_expired) begin
          w_next = ST_MONITOR;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_tmr_load     = (w_next != r_state);
    w_tmr_load_val = '0;
    case (w_next)
      ST_JAMMED, ST_SPOOF: w_tmr_load_val = c_ent_load;
      ST_COUNTER_MEAS:     w_tmr_load_val = c_cm_load;
      ST_RECOVERY:         w_tmr_load_val = c_rec_load;
      default:             w_tmr_load_val = '0;
    endcase
  end

  always_comb begin
    fsm_state = FSM_BITS'(r_state);
    ent_req   = is_threat(r_state);
    cm_req    = (r_state == ST_COUNTER_MEAS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_verdict <= 1'b0;
    end else if (is_threat(r_state) && ent_valid) begin
      r_verdict <= ent_high;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cm_err <= 1'b0;
    end else if ((r_state == ST_COUNTER_MEAS) && w_tmr_expired && !cm_ack) begin
      r_cm_err <= 1'b1;
    end
  end

  assign cm_timeout_err = r_cm_err;

`ifdef EW_THREAT_CNT_EN
  logic       w_threat_entry;
  logic [7:0] r_threat_cnt;

  assign w_threat_entry = is_threat(w_next) && !is_threat(r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_threat_cnt <= 8'd0;
    end else if (w_threat_entry && (r_threat_cnt != 8'hFF)) begin
      r_threat_cnt <= r_threat_cnt + 8'd1;
    end
  end

  assign threat_cnt = r_threat_cnt;
`else
  assign threat_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ew_threat_fsm.sv
// +--------------------------------------------------------------------------+
// | tb_ew_threat_fsm : directed + random bench with behavioural model.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ew_threat_fsm;

  localparam int ENT_T = 32;
  localparam int CM_T  = 64;
  localparam int REC_T = 16;
`ifdef EW_THREAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jam_det = 1'b0;
  logic       spoof_det = 1'b0;
  logic       ent_valid = 1'b0;
  logic       ent_high = 1'b0;
  logic       cm_ack = 1'b0;
  logic [2:0] fsm_state;
  logic       ent_req;
  logic       cm_req;
  logic       cm_timeout_err;
  logic [7:0] threat_cnt;

  ew_threat_fsm #(
    .FSM_BITS    (3),
    .ENT_TIMEOUT (ENT_T),
    .CM_TIMEOUT  (CM_T),
    .REC_CYCLES  (REC_T)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jam_det        (jam_det),
    .spoof_det      (spoof_det),
    .ent_valid      (ent_valid),
    .ent_high       (ent_high),
    .cm_ack         (cm_ack),
    .fsm_state      (fsm_state),
    .ent_req        (ent_req),
    .cm_req         (cm_req),
    .cm_timeout_err (cm_timeout_err),
    .threat_cnt     (threat_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state number plus cycles spent in it (1 on entry).
  int m_st = 0;
  int m_el = 1;
  int m_cnt = 0;
  bit m_verdict = 0;
  bit m_err = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int nx;
    nx = m_st;
    if (rst) begin
      m_st = 0; m_el = 1; m_cnt = 0; m_verdict = 0; m_err = 0;
    end else begin
      case (m_st)
        0: nx = 1;
        1: if (jam_det) nx = 2; else if (spoof_det) nx = 3;
        2, 3: begin
          if (ent_valid) begin nx = 4; m_verdict = ent_high; end
          else if (m_el >= ENT_T) nx = 5;
        end
        4: nx = m_verdict ? 5 : 1;
        5: begin
          if (cm_ack) nx = 6;
          else if (m_el >= CM_T) begin nx = 6; m_err = 1; end
        end
        6: if (m_el >= REC_T) nx = 1;
        default: nx = 0;
      endcase
      if ((nx == 2 || nx == 3) && m_st == 1 && m_cnt < 255) m_cnt++;
      m_el = (nx != m_st) ? 1 : m_el + 1;
      m_st = nx;
    end
    m_valid = 1;
  end

  int prev_st = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("fsm_state", int'(fsm_state), m_st);
      chk("ent_req", int'(ent_req), int'(m_st == 2 || m_st == 3));
      chk("cm_req", int'(cm_req), int'(m_st == 5));
      chk("cm_timeout_err", int'(cm_timeout_err), int'(m_err));
      chk("threat_cnt", int'(threat_cnt), CNT_ON ? m_cnt : 0);
      chk("jammed_to_recovery", int'(prev_st == 2 && fsm_state == 3'd6), 0);
      prev_st = int'(fsm_state);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic to_cm_via_verdict();
    jam_det = 1'b1; tick();
    jam_det = 1'b0; ent_valid = 1'b1; ent_high = 1'b1; tick();
    ent_valid = 1'b0; ent_high = 1'b0; tick();
  endtask

  initial begin
    // Reset and release
    tick(); tick();
    chk("rst_state", int'(fsm_state), 0);
    chk("rst_cnt", int'(threat_cnt), 0);
    rst = 1'b0;
    chk("rel_cycle1_idle", int'(fsm_state), 0);
    tick();
    chk("rel_cycle2_monitor", int'(fsm_state), 1);

    // Simultaneous jam/spoof, high verdict, acked countermeasure
    jam_det = 1'b1; spoof_det = 1'b1; tick();
    jam_det = 1'b0; spoof_det = 1'b0;
    chk("both_det_jammed", int'(fsm_state), 2);
    chk("first_entry_cnt", int'(threat_cnt), CNT_ON ? 1 : 0);
    chk("jammed_ent_req", int'(ent_req), 1);
    tick();
    ent_valid = 1'b1; ent_high = 1'b1; tick();
    ent_valid = 1'b0; ent_high = 1'b0;
    chk("ent_analyzed", int'(fsm_state), 4);
    tick();
    chk("verdict_high_cm", int'(fsm_state), 5);
    chk("cm_req_high", int'(cm_req), 1);
    tick();
    cm_ack = 1'b1; tick();
    cm_ack = 1'b0;
    chk("ack_recovery", int'(fsm_state), 6);
    repeat (REC_T - 1) tick();
    chk("recovery_last_cycle", int'(fsm_state), 6);
    tick();
    chk("recovery_done_monitor", int'(fsm_state), 1);

    // Spoof with no verdict, then CM timeout
    spoof_det = 1'b1; tick();
    spoof_det = 1'b0;
    chk("spoof_entry", int'(fsm_state), 3);
    repeat (ENT_T - 1) tick();
    chk("spoof_last_cycle", int'(fsm_state), 3);
    tick();
    chk("ent_timeout_cm", int'(fsm_state), 5);
    repeat (CM_T - 1) tick();
    chk("cm_last_cycle", int'(fsm_state), 5);
    chk("cm_err_not_yet", int'(cm_timeout_err), 0);
    tick();
    chk("cm_timeout_recovery", int'(fsm_state), 6);
    chk("cm_timeout_err_set", int'(cm_timeout_err), 1);
    repeat (REC_T) tick();
    chk("cm_err_sticky", int'(cm_timeout_err), 1);
    chk("back_to_monitor", int'(fsm_state), 1);

    // Ack on the very last CM cycle wins over the timeout
    reset_dut();
    chk("err_cleared_by_rst", int'(cm_timeout_err), 0);
    to_cm_via_verdict();
    repeat (CM_T - 1) tick();
    chk("cm_cycle64", int'(fsm_state), 5);
    cm_ack = 1'b1; tick();
    cm_ack = 1'b0;
    chk("ack_at_64_recovery", int'(fsm_state), 6);
    chk("ack_at_64_no_err", int'(cm_timeout_err), 0);
    repeat (REC_T) tick();

    // Reset mid-countermeasure
    to_cm_via_verdict();
    chk("cm_req_before_rst", int'(cm_req), 1);
    rst = 1'b1; tick();
    chk("rst_in_cm_state", int'(fsm_state), 0);
    chk("rst_in_cm_cm_req", int'(cm_req), 0);
    chk("rst_in_cm_ent_req", int'(ent_req), 0);
    chk("rst_in_cm_cnt", int'(threat_cnt), 0);
    rst = 1'b0; tick();

    // 300 threat entries saturate the counter
    for (int i = 0; i < 300; i++) begin
      jam_det = 1'b1; tick();
      jam_det = 1'b0; ent_valid = 1'b1; ent_high = 1'b0; tick();
      ent_valid = 1'b0; tick();
    end
    chk("cnt_saturated", int'(threat_cnt), CNT_ON ? 255 : 0);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      rst       = ($urandom_range(999) < 2);
      jam_det   = ($urandom_range(99) < 10);
      spoof_det = ($urandom_range(99) < 10);
      ent_valid = ($urandom_range(99) < 5);
      ent_high  = $urandom_range(1);
      cm_ack    = ($urandom_range(99) < 3);
      tick();
    end
    rst = 1'b0; jam_det = 1'b0; spoof_det = 1'b0;
    ent_valid = 1'b0; ent_high = 1'b0; cm_ack = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
